// File: rtl/nibble_serial_add_seq_if.sv
// Bundle of the operand, adder and result signals around nibble_serial_add_seq.
// The out_ovf member exists only when SERIAL_ADD_OVF_EN is defined.
interface nibble_serial_add_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // Both handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid never waits on ready, and ready here depends only on the block's state.
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
`ifdef SERIAL_ADD_OVF_EN
  logic         out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_carry, out_ovf
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_carry, out_ovf
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_carry
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_carry
  );
`endif
endinterface

// File: rtl/nibble_serial_add_seq.sv
// Wide adder sequencer: feeds an external 4-bit adder one nibble per cycle, LSB first.
// Optional signed-overflow flag enabled by the SERIAL_ADD_OVF_EN macro.
module nibble_serial_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_serial_add_seq_if.slave bus,
  output logic [1:0]             dbg_state_o
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW+1:0] nib_lo;
  logic          last_nib;
`ifdef SERIAL_ADD_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  assign nib_lo   = {k_q, 2'b00};
  assign last_nib = (k_q == KW'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    sum_d         = sum_q;
    carry_d       = carry_q;
    k_d           = k_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d         = ovf_q;
`endif
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = 4'h0;
    bus.add_b     = 4'h0;
    bus.add_cin   = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          opa_d   = bus.in_a;
          opb_d   = bus.in_b;
          carry_d = bus.in_cin;
          k_d     = '0;
          sum_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        bus.add_a   = opa_q[nib_lo +: 4];
        bus.add_b   = opb_q[nib_lo +: 4];
        bus.add_cin = carry_q;
        sum_d[nib_lo +: 4] = bus.add_sum;
        carry_d     = bus.add_cout;
        k_d         = k_q + KW'(1);
        if (last_nib) begin
          state_d = S_DONE;
`ifdef SERIAL_ADD_OVF_EN
          // Same-sign operands whose top sum bit differs from that sign.
          ovf_d = (opa_q[W-1] == opb_q[W-1]) && (bus.add_sum[3] != opa_q[W-1]);
`endif
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.out_sum   = sum_q;
  assign bus.out_carry = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.out_ovf   = ovf_q;
`endif
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Directed bench for nibble_serial_add_seq with NIBBLES=4 and a behavioural 4-bit adder.
// Overflow checks are compiled in when SERIAL_ADD_OVF_EN is defined.
module tb_nibble_serial_add_seq;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  nibble_serial_add_seq_if #(.NIBBLES(4)) bus ();

  nibble_serial_add_seq #(.NIBBLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // The external ripple adder the sequencer drives.
  assign {bus.add_cout, bus.add_sum} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand pair in IDLE; returns 1ns after the accepting edge.
  task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    bus.in_cin   = ~cin;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_sum !== 16'h0000) begin errors++; $display("FAIL reset_out_sum: got %h expected 0000", bus.out_sum); end
    checks++; if (bus.out_carry !== 1'b0) begin errors++; $display("FAIL reset_out_carry: got %b expected 0", bus.out_carry); end
    checks++; if ({bus.add_a, bus.add_b, bus.add_cin} !== 9'h000) begin errors++; $display("FAIL reset_adder_in: got %h/%h/%b expected 0/0/0", bus.add_a, bus.add_b, bus.add_cin); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
`ifdef SERIAL_ADD_OVF_EN
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b expected 0", bus.out_ovf); end
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [3:0] exp_a [4];
    exp_a = '{4'h4, 4'h3, 4'h2, 4'h1};
    drive_op(16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.add_a !== exp_a[i]) begin errors++; $display("FAIL basic_add_a[%0d]: got %h expected %h", i, bus.add_a, exp_a[i]); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid[%0d]: got %b expected 0", i, bus.out_valid); end
      @(posedge clk); #1;
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_sum !== 16'h5555) begin errors++; $display("FAIL basic_sum: got %h expected 5555", bus.out_sum); end
    checks++; if (bus.out_carry !== 1'b0) begin errors++; $display("FAIL basic_carry: got %b expected 0", bus.out_carry); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_no_bypass: got %b expected 0", bus.in_ready); end
    checks++; if (bus.add_a !== 4'h0) begin errors++; $display("FAIL basic_done_add_a: got %h expected 0", bus.add_a); end
`ifdef SERIAL_ADD_OVF_EN
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", bus.out_ovf); end
`endif
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_return_idle: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_carry_chain();
    logic exp_cin [4];
    exp_cin = '{1'b0, 1'b1, 1'b1, 1'b1};
    drive_op(16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.add_cin !== exp_cin[i]) begin errors++; $display("FAIL chain_add_cin[%0d]: got %b expected %b", i, bus.add_cin, exp_cin[i]); end
      @(posedge clk); #1;
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL chain_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_sum !== 16'h0000) begin errors++; $display("FAIL chain_sum: got %h expected 0000", bus.out_sum); end
    checks++; if (bus.out_carry !== 1'b1) begin errors++; $display("FAIL chain_carry: got %b expected 1", bus.out_carry); end
    @(posedge clk); #1;
  endtask

  task automatic test_cin_ovf();
    drive_op(16'h0000, 16'h0000, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL cin_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_sum !== 16'h0001) begin errors++; $display("FAIL cin_sum: got %h expected 0001", bus.out_sum); end
    checks++; if (bus.out_carry !== 1'b0) begin errors++; $display("FAIL cin_carry: got %b expected 0", bus.out_carry); end
    @(posedge clk); #1;
    drive_op(16'h7FFF, 16'h0001, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (bus.out_sum !== 16'h8000) begin errors++; $display("FAIL ovf_sum: got %h expected 8000", bus.out_sum); end
    checks++; if (bus.out_carry !== 1'b0) begin errors++; $display("FAIL ovf_carry: got %b expected 0", bus.out_carry); end
`ifdef SERIAL_ADD_OVF_EN
    checks++; if (bus.out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus.out_ovf); end
`endif
    @(posedge clk); #1;
`ifdef SERIAL_ADD_OVF_EN
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.out_ovf); end
`endif
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive_op(16'h1111, 16'h2222, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0F0F;
    bus.in_b     = 16'h0F0F;
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h3333) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b sum=%h expected valid=1 sum=3333", i, bus.out_valid, bus.out_sum); end
      checks++; if (bus.in_ready !== 1'b0 || bus.add_a !== 4'h0) begin errors++; $display("FAIL bp_idle_side[%0d]: got ready=%b add_a=%h expected ready=0 add_a=0", i, bus.in_ready, bus.add_a); end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.add_a !== 4'h0 || dbg_state !== 2'd0) begin errors++; $display("FAIL bp_no_accept: got add_a=%h state=%0d expected add_a=0 state=0", bus.add_a, dbg_state); end
  endtask

  task automatic test_reset_mid();
    drive_op(16'hABCD, 16'h1111, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (bus.out_sum !== 16'h00DE) begin errors++; $display("FAIL mid_partial: got %h expected 00de", bus.out_sum); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_sum !== 16'h0000 || bus.out_carry !== 1'b0) begin errors++; $display("FAIL mid_reset_result: got sum=%h carry=%b expected 0000/0", bus.out_sum, bus.out_carry); end
    checks++; if (bus.in_ready !== 1'b1 || bus.add_a !== 4'h0 || bus.add_b !== 4'h0) begin errors++; $display("FAIL mid_reset_ctrl: got ready=%b a=%h b=%h expected 1/0/0", bus.in_ready, bus.add_a, bus.add_b); end
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_pulse[%0d]: got %b expected 0", i, bus.out_valid); end
      @(posedge clk); #1;
    end
    drive_op(16'h0101, 16'h0202, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 16'h0303) begin errors++; $display("FAIL mid_next_op: got valid=%b sum=%h expected 1/0303", bus.out_valid, bus.out_sum); end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_cin_ovf();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
